// File: rtl/sm_muldiv_pkg.sv
// Shared op codes and state encodings for the iterative multiply/divide unit.
package sm_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdState_e;

endpackage

// File: rtl/sm_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module sm_muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               divMode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] accNext,
    output logic               qBit
);

    logic [WIDTH:0] mulSum;
    logic [WIDTH:0] divRem;
    logic [WIDTH:0] divDiff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}.
    always_comb begin
        mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        divRem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divDiff = divRem - {1'b0, opnd};
        qBit    = divMode & ~divDiff[WIDTH];
        if (divMode) begin
            accNext = {(qBit ? divDiff[WIDTH-1:0] : divRem[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end else begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers; WIDTH+1 clocks per op.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    mdState_e           state, stateNext;
    logic               isDiv, isDivNext;
    logic               negRes, negResNext;
    logic               negRem, negRemNext;
    logic [ACC_W-1:0]   acc, accNext;
    logic [WIDTH-1:0]   opnd, opndNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [WIDTH-1:0]   hiNext, loNext;
    logic               doneNext;

    logic               signedOp;
    logic [WIDTH-1:0]   absA, absB;
    logic [ACC_W-1:0]   product;
    logic [WIDTH-1:0]   quot, rem;
    logic [ACC_W-1:0]   stepAcc;
    logic               stepQ;

    sm_muldiv_step #(.WIDTH(WIDTH)) uStep (
        .divMode (isDiv),
        .acc     (acc),
        .opnd    (opnd),
        .accNext (stepAcc),
        .qBit    (stepQ)
    );

    assign busy = (state != S_IDLE);

    // Next-state, datapath and result-register logic.
    always_comb begin
        stateNext  = state;
        isDivNext  = isDiv;
        negResNext = negRes;
        negRemNext = negRem;
        accNext    = acc;
        opndNext   = opnd;
        cntNext    = cnt;
        hiNext     = hi;
        loNext     = lo;
        doneNext   = 1'b0;

        signedOp = (op == MD_MULT) || (op == MD_DIV);
        absA     = (signedOp && srcA[WIDTH-1]) ? -srcA : srcA;
        absB     = (signedOp && srcB[WIDTH-1]) ? -srcB : srcB;
        product  = negRes ? -acc : acc;
        quot     = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = negRem ? -acc[ACC_W-1:WIDTH] : acc[ACC_W-1:WIDTH];

        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            stateNext  = S_CALC;
                            isDivNext  = op[1];
                            negResNext = signedOp && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                            negRemNext = signedOp && srcA[WIDTH-1];
                            accNext    = {WIDTH'(0), absA};
                            opndNext   = absB;
                            cntNext    = '0;
                        end
                        MD_MTHI: hiNext = srcA;
                        MD_MTLO: loNext = srcA;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (abort) begin
                    stateNext = S_IDLE;
                end else begin
                    accNext = stepAcc | ACC_W'(stepQ);
                    cntNext = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) stateNext = S_FIX;
                end
            end
            S_FIX: begin
                stateNext = S_IDLE;
                if (!abort) begin
                    doneNext = 1'b1;
                    if (isDiv) begin
                        // Divide by zero leaves |dividend| in the remainder; sign fixup restores srcA.
                        hiNext = rem;
                        loNext = (opnd == '0) ? '1 : quot;
                    end else begin
                        {hiNext, loNext} = product;
                    end
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            isDiv  <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            state  <= stateNext;
            isDiv  <= isDivNext;
            negRes <= negResNext;
            negRem <= negRemNext;
            acc    <= accNext;
            opnd   <= opndNext;
            cnt    <= cntNext;
            hi     <= hiNext;
            lo     <= loNext;
            done   <= doneNext;
        end
    end

endmodule
